fft_sequencer: RTL and testbench
================================

FFT_SEQUENCER -- requirements
Module: fft_sequencer

Interface
REQ-001 SHALL have parameter MAX_LOG2N, default 10, meaning the largest supported transform is 2^MAX_LOG2N points.
REQ-002 SHALL have parameter MAX_OUTST, default 4, meaning the maximum number of issued butterflies not yet acknowledged.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port start_i, input, 1 bit: one-cycle request to begin a transform.
REQ-006 SHALL have port log2n_i, input, 4 bits: transform size exponent, sampled on an accepted start.
REQ-007 SHALL have port op_valid_o, output, 1 bit: a butterfly descriptor is presented.
REQ-008 SHALL have port op_ready_i, input, 1 bit: the datapath accepts the descriptor.
REQ-009 SHALL have port op_addr_a_o, output, MAX_LOG2N bits: index of the upper operand.
REQ-010 SHALL have port op_addr_b_o, output, MAX_LOG2N bits: index of the lower operand.
REQ-011 SHALL have port op_tw_idx_o, output, MAX_LOG2N-1 bits: twiddle table index.
REQ-012 SHALL have port op_stage_o, output, 4 bits: current stage number.
REQ-013 SHALL have port op_last_o, output, 1 bit: the descriptor is the final one of the transform.
REQ-014 SHALL have port wb_ack_i, input, 1 bit: one butterfly result has been written back.
REQ-015 SHALL have port busy_o, output, 1 bit: a transform is in progress.
REQ-016 SHALL have port done_o, output, 1 bit: one-cycle pulse when the transform completes.
REQ-017 SHALL have port err_o, output, 1 bit: sticky flag for an illegal log2n_i; cleared by the next accepted start.

Function
REQ-018 SHALL implement the states IDLE, ISSUE, DRAIN and DONE.
REQ-019 IDLE: when start_i=1 and 1<=log2n_i<=MAX_LOG2N, SHALL latch N_LOG=log2n_i, set stage s=0 and butterfly k=0, clear err_o, and enter ISSUE the next cycle.
REQ-020 IDLE: when start_i=1 and log2n_i is 0 or >MAX_LOG2N, SHALL set err_o=1 and remain in IDLE; done_o SHALL NOT pulse.
REQ-021 ISSUE: SHALL drive op_valid_o=1 only while outstanding<MAX_OUTST; a transfer SHALL occur only on a cycle with op_valid_o=1 and op_ready_i=1.
REQ-022 Descriptor for stage s and butterfly k, with h=2^s, g=k>>s and p=k&(h-1): addr_a=g*2h+p, addr_b=addr_a+h, tw_idx=p<<(N_LOG-1-s), op_stage_o=s (radix-2 DIT, bit-reversed input order).
REQ-023 While op_valid_o=1 and op_ready_i=0, the descriptor outputs SHALL remain stable.
REQ-024 On each transfer, k SHALL increment; on the transfer with k=2^(N_LOG-1)-1, the FSM SHALL go to DRAIN and k SHALL wrap to 0.
REQ-025 DRAIN: SHALL hold op_valid_o=0 until outstanding=0 (stage barrier); then SHALL go to ISSUE with s+1 if s<N_LOG-1, otherwise to DONE.
REQ-026 op_last_o SHALL be 1 only when s=N_LOG-1 and k=2^(N_LOG-1)-1.
REQ-027 outstanding SHALL be a counter that adds 1 per transfer and subtracts 1 per wb_ack_i; when both happen in the same cycle it SHALL be unchanged.
REQ-028 A wb_ack_i received while outstanding=0 SHALL be ignored (saturate at 0).
REQ-029 DONE: SHALL pulse done_o for one cycle and return to IDLE.
REQ-030 busy_o SHALL be 1 in ISSUE, DRAIN and DONE, and 0 in IDLE.
REQ-031 start_i SHALL be ignored whenever the state is not IDLE.
REQ-032 Total transfers per transform SHALL equal N_LOG*2^(N_LOG-1).

Reset
REQ-033 While rst_ni=0, SHALL asynchronously force state=IDLE, s=0, k=0, outstanding=0, op_valid_o=0, op_last_o=0, busy_o=0, done_o=0 and err_o=0; all address, twiddle and stage outputs SHALL be 0.
REQ-034 A reset asserted mid-transform SHALL abandon the transform with no done_o pulse; the first start after reset SHALL begin again from s=0.

Verification
REQ-035 log2n_i=3, op_ready_i=1, wb_ack_i one cycle after each transfer -> 12 transfers; stage-0 pairs (0,1)(2,3)(4,5)(6,7) with tw 0; stage-1 pairs (0,2)(1,3)(4,6)(5,7) with tw 0,2,0,2; stage-2 pairs (0,4)(1,5)(2,6)(3,7) with tw 0,1,2,3; op_last_o on the 12th; done_o one pulse.
REQ-036 log2n_i=2 with op_ready_i held 0 for 5 cycles on the first descriptor -> outputs stable for all 5 cycles; the transfer sequence is unchanged afterwards.
REQ-037 MAX_OUTST=4, no wb_ack_i -> op_valid_o drops after 4 transfers; each later ack releases exactly one more transfer.
REQ-038 Stage barrier: last stage-0 ack delayed 10 cycles -> no stage-1 descriptor appears until the cycle after that ack.
REQ-039 start_i with log2n_i=0, then with log2n_i=11 -> err_o=1, busy_o=0; a following valid start clears err_o.
REQ-040 rst_ni pulsed low during stage 1 of log2n_i=4 -> all outputs 0 immediately, no done_o pulse; a new start produces the full 32-transfer sequence.

Source files
------------

// File: rtl/fft_sequencer_if.sv
// Butterfly descriptor channel between the FFT sequencer (master) and the datapath (slave),
// including the per-butterfly write-back acknowledge returned by the datapath.
interface fft_sequencer_if #(
    parameter int MAX_LOG2N = 10
);
    logic                   op_valid_o;
    logic                   op_ready_i;
    logic [MAX_LOG2N-1:0]   op_addr_a_o;
    logic [MAX_LOG2N-1:0]   op_addr_b_o;
    logic [MAX_LOG2N-2:0]   op_tw_idx_o;
    logic [3:0]             op_stage_o;
    logic                   op_last_o;
    logic                   wb_ack_i;

    modport master (
        output op_valid_o, op_addr_a_o, op_addr_b_o, op_tw_idx_o, op_stage_o, op_last_o,
        input  op_ready_i, wb_ack_i
    );

    modport slave (
        input  op_valid_o, op_addr_a_o, op_addr_b_o, op_tw_idx_o, op_stage_o, op_last_o,
        output op_ready_i, wb_ack_i
    );
endinterface

// File: rtl/fft_sequencer.sv
// Address sequencer for an in-place radix-2 DIT FFT: walks stages and butterflies,
// throttles on outstanding write-backs and holds a barrier between stages.
module fft_sequencer #(
    parameter int MAX_LOG2N = 10,
    parameter int MAX_OUTST = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [3:0]      log2n_i,
    fft_sequencer_if.master op,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o
);
    localparam int AW = MAX_LOG2N;
    localparam int KW = MAX_LOG2N - 1;
    localparam int TW = MAX_LOG2N - 1;
    localparam int OW = $clog2(MAX_OUTST + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE} state_e;

    state_e         state_q, state_d;
    logic [3:0]     n_log_q, n_log_d;
    logic [3:0]     s_q, s_d;
    logic [KW-1:0]  k_q, k_d;
    logic [OW-1:0]  outst_q, outst_d;
    logic           err_q, err_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           valid_q, valid_d;
    logic           last_q, last_d;
    logic [AW-1:0]  addr_a_q, addr_a_d;
    logic [AW-1:0]  addr_b_q, addr_b_d;
    logic [TW-1:0]  tw_q, tw_d;
    logic [3:0]     stage_q, stage_d;

    logic           fire;
    logic           ack_eff;
    logic           start_ok;
    logic           issuing;
    logic [AW-1:0]  h, kx, p, g, a;

    function automatic logic [KW-1:0] last_k(input logic [3:0] n);
        logic [AW-1:0] half;
        half = AW'(1) << (n - 4'd1);
        return KW'(half - AW'(1));
    endfunction

    assign start_ok = start_i && (log2n_i != 4'd0) && (int'(log2n_i) <= MAX_LOG2N);

    always_comb begin
        state_d = state_q;
        n_log_d = n_log_q;
        s_d     = s_q;
        k_d     = k_q;
        err_d   = err_q;

        fire    = valid_q & op.op_ready_i;
        // Acks with nothing outstanding are spurious and must not underflow the counter.
        ack_eff = op.wb_ack_i & (outst_q != '0);
        outst_d = outst_q;
        if (fire && !ack_eff) begin
            outst_d = outst_q + OW'(1);
        end else if (!fire && ack_eff) begin
            outst_d = outst_q - OW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (start_ok) begin
                        n_log_d = log2n_i;
                        s_d     = 4'd0;
                        k_d     = '0;
                        err_d   = 1'b0;
                        state_d = ST_ISSUE;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (fire) begin
                    if (k_q == last_k(n_log_q)) begin
                        k_d     = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        k_d     = k_q + KW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                // Leave the barrier on the edge that retires the final write-back.
                if (outst_d == '0) begin
                    if (s_q == n_log_q - 4'd1) begin
                        state_d = ST_DONE;
                    end else begin
                        s_d     = s_q + 4'd1;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        h  = AW'(1) << s_d;
        kx = AW'(k_d);
        p  = kx & (h - AW'(1));
        g  = kx >> s_d;
        a  = (g << (s_d + 4'd1)) | p;

        issuing  = (state_d == ST_ISSUE);
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_DONE);
        valid_d  = issuing && (outst_d < OW'(MAX_OUTST));
        addr_a_d = issuing ? a : '0;
        addr_b_d = issuing ? (a | h) : '0;
        tw_d     = issuing ? TW'(p << (n_log_d - 4'd1 - s_d)) : '0;
        stage_d  = issuing ? s_d : 4'd0;
        last_d   = issuing && (s_d == n_log_d - 4'd1) && (k_d == last_k(n_log_d));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            n_log_q  <= 4'd0;
            s_q      <= 4'd0;
            k_q      <= '0;
            outst_q  <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            tw_q     <= '0;
            stage_q  <= 4'd0;
        end else begin
            state_q  <= state_d;
            n_log_q  <= n_log_d;
            s_q      <= s_d;
            k_q      <= k_d;
            outst_q  <= outst_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            tw_q     <= tw_d;
            stage_q  <= stage_d;
        end
    end

    assign op.op_valid_o  = valid_q;
    assign op.op_addr_a_o = addr_a_q;
    assign op.op_addr_b_o = addr_b_q;
    assign op.op_tw_idx_o = tw_q;
    assign op.op_stage_o  = stage_q;
    assign op.op_last_o   = last_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign err_o          = err_q;
endmodule

// File: tb/tb_fft_sequencer.sv
// Self-checking bench for fft_sequencer: expected butterfly order comes from a block/pair
// enumeration of each stage; handshake timing from a small phase/outstanding model.
module tb_fft_sequencer;
    localparam int MAXL = 10;
    localparam int MAXO = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] log2n;
    logic       busy, done, err;

    fft_sequencer_if #(.MAX_LOG2N(MAXL)) bus ();

    fft_sequencer #(.MAX_LOG2N(MAXL), .MAX_OUTST(MAXO)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (start),
        .log2n_i (log2n),
        .op      (bus),
        .busy_o  (busy),
        .done_o  (done),
        .err_o   (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int tw;
        int stage;
    } desc_t;

    desc_t exp_q[$];
    int    total = 0;
    int    bad = 0;
    int    xfers_seen, dones_seen, lasts_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, bus.op_valid_o, 0);
        check({tag, "_last"}, bus.op_last_o, 0);
        check({tag, "_addr_a"}, bus.op_addr_a_o, 0);
        check({tag, "_addr_b"}, bus.op_addr_b_o, 0);
        check({tag, "_tw"}, bus.op_tw_idx_o, 0);
        check({tag, "_stage"}, bus.op_stage_o, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
    endtask

    // Each stage splits the N points into blocks of 2h; pair p of a block joins p and p+h.
    function automatic void build_expected(input int n);
        int npts, h, span;
        desc_t d;
        exp_q.delete();
        npts = 1 << n;
        for (int s = 0; s < n; s++) begin
            h    = 1 << s;
            span = 2 * h;
            for (int g = 0; g < npts / span; g++) begin
                for (int p = 0; p < h; p++) begin
                    d.a     = g * span + p;
                    d.b     = g * span + p + h;
                    d.tw    = p * (npts / span);
                    d.stage = s;
                    exp_q.push_back(d);
                end
            end
        end
    endfunction

    task automatic run_xform(input int n, input int ready_pct, input int max_dly, input int stall_first,
                             input int ack_hold, input int barrier_dly, input int abort_at);
        int          phase, outst, remain, stage, cyc, dly, stall_left;
        bit          rdy, ack, fire, ack_eff, exp_valid, held;
        logic [31:0] sv_a, sv_b, sv_tw, sv_st;
        int          pend[$];
        desc_t       d;

        build_expected(n);
        xfers_seen = 0;
        dones_seen = 0;
        lasts_seen = 0;
        held       = 1'b0;
        sv_a = 0; sv_b = 0; sv_tw = 0; sv_st = 0;
        stall_left = stall_first;

        start = 1'b1;
        log2n = 4'(n);
        @(posedge clk); #1;
        start = 1'b0;

        phase  = 1;
        outst  = 0;
        remain = 1 << (n - 1);
        stage  = 0;
        cyc    = 0;

        while (phase != 0) begin
            if (cyc > 20000) begin
                check("timeout_phase", phase, 0);
                break;
            end
            if (abort_at > 0 && xfers_seen == abort_at) begin
                start = 1'b0;
                bus.op_ready_i = 1'b0;
                bus.wb_ack_i = 1'b0;
                rst_n = 1'b0;
                #1;
                check_zero("abort");
                #1 rst_n = 1'b1;
                repeat (3) begin
                    @(posedge clk); #1;
                    check("abort_no_done", done, 0);
                    check("abort_idle_busy", busy, 0);
                end
                return;
            end

            exp_valid = (phase == 1) && (outst < MAXO);
            check("busy", busy, (phase != 0));
            check("done", done, (phase == 3));
            check("err_clear", err, 0);
            check("valid", bus.op_valid_o, exp_valid);
            if (done) dones_seen++;
            if (held) begin
                check("hold_addr_a", bus.op_addr_a_o, sv_a);
                check("hold_addr_b", bus.op_addr_b_o, sv_b);
                check("hold_tw", bus.op_tw_idx_o, sv_tw);
                check("hold_stage", bus.op_stage_o, sv_st);
            end

            if (exp_valid && stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end else begin
                rdy = ($urandom_range(99) < ready_pct);
            end
            ack = (cyc >= ack_hold) && (pend.size() > 0) && (pend[0] <= cyc);
            if (ack) void'(pend.pop_front());
            start = ($urandom_range(7) == 0);
            log2n = 4'($urandom_range(15));
            bus.op_ready_i = rdy;
            bus.wb_ack_i = ack;

            fire = exp_valid && rdy;
            held = exp_valid && !rdy;
            if (held) begin
                sv_a  = 32'(bus.op_addr_a_o);
                sv_b  = 32'(bus.op_addr_b_o);
                sv_tw = 32'(bus.op_tw_idx_o);
                sv_st = 32'(bus.op_stage_o);
            end
            if (fire) begin
                if (exp_q.size() == 0) begin
                    check("extra_xfer", exp_q.size(), 1);
                end else begin
                    d = exp_q.pop_front();
                    check("addr_a", bus.op_addr_a_o, d.a);
                    check("addr_b", bus.op_addr_b_o, d.b);
                    check("tw_idx", bus.op_tw_idx_o, d.tw);
                    check("stage", bus.op_stage_o, d.stage);
                    check("last", bus.op_last_o, (exp_q.size() == 0));
                end
                if (bus.op_last_o) lasts_seen++;
                xfers_seen++;
                dly = (barrier_dly > 0 && stage == 0 && remain == 1) ? barrier_dly : $urandom_range(max_dly, 1);
                pend.push_back(cyc + dly);
            end

            ack_eff = ack && (outst > 0);
            outst   = outst + int'(fire) - int'(ack_eff);
            case (phase)
                1: if (fire) begin
                    remain--;
                    if (remain == 0) phase = 2;
                end
                2: if (outst == 0) begin
                    if (stage < n - 1) begin
                        stage++;
                        remain = 1 << (n - 1);
                        phase  = 1;
                    end else begin
                        phase = 3;
                    end
                end
                3: phase = 0;
                default: phase = 0;
            endcase

            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        bus.op_ready_i = 1'b0;
        bus.wb_ack_i = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        log2n = 4'd0;
        bus.op_ready_i = 1'b0;
        bus.wb_ack_i = 1'b0;
        #2 rst_n = 1'b0;
        #2;
        check_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_zero("idle_after_reset");

        run_xform(3, 100, 1, 0, 0, 0, 0);
        check("n3_xfers", xfers_seen, 12);
        check("n3_dones", dones_seen, 1);
        check("n3_lasts", lasts_seen, 1);

        run_xform(2, 100, 1, 5, 0, 0, 0);
        check("n2_stall_xfers", xfers_seen, 4);

        run_xform(3, 100, 1, 0, 8, 0, 0);
        check("throttle_xfers", xfers_seen, 12);

        run_xform(3, 100, 1, 0, 0, 10, 0);
        check("barrier_xfers", xfers_seen, 12);

        start = 1'b1;
        log2n = 4'd0;
        @(posedge clk); #1;
        start = 1'b0;
        check("err_log0", err, 1);
        check("err_log0_busy", busy, 0);
        start = 1'b1;
        log2n = 4'd11;
        @(posedge clk); #1;
        start = 1'b0;
        check("err_log11", err, 1);
        check("err_log11_busy", busy, 0);
        @(posedge clk); #1;
        check("err_sticky", err, 1);
        check("err_no_done", done, 0);

        bus.wb_ack_i = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        bus.wb_ack_i = 1'b0;
        run_xform(2, 100, 2, 0, 0, 0, 0);
        check("after_err_xfers", xfers_seen, 4);

        run_xform(4, 100, 2, 0, 0, 0, 10);
        run_xform(4, 70, 3, 0, 0, 0, 0);
        check("after_abort_xfers", xfers_seen, 32);
        check("after_abort_dones", dones_seen, 1);

        for (int r = 0; r < 4; r++) begin
            int rn, rp, rd;
            rn = $urandom_range(6, 1);
            rp = $urandom_range(100, 40);
            rd = $urandom_range(6, 1);
            run_xform(rn, rp, rd, 0, 0, 0, 0);
            check("rand_xfers", xfers_seen, rn * (1 << (rn - 1)));
        end

        run_xform(MAXL, 100, 3, 0, 0, 0, 0);
        check("max_xfers", xfers_seen, MAXL * (1 << (MAXL - 1)));
        check("max_lasts", lasts_seen, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
